blockram_lsu: RTL

Parametrised dual-port data memory for the single-cycle core: port A is a byte-addressed load/store port with RISC-V size/sign handling and misalignment detection, port B is a read-only word port for instruction fetch. After every reset, a built-in clear engine zeroes the whole array, so the core never needs to pre-initialise memory.

---
 rtl/blockram_lsu.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/blockram_lsu.sv
// Dual-port data memory: byte-addressed RISC-V load/store port A, read-only word port B.
// A clear engine zeroes the array after every reset. Define BLOCKRAM_LSU_BYPASS_EN for write-first port B.
module blockram_lsu #(
  parameter int BYTE_WIDTH    = 8,
  parameter int BYTES         = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 1024,
  localparam int DATA_WIDTH   = BYTE_WIDTH * BYTES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_req,
  input  logic                     a_we,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [1:0]               a_size,
  input  logic                     a_unsigned,
  input  logic [DATA_WIDTH-1:0]    a_wdata,
  output logic [DATA_WIDTH-1:0]    a_rdata,
  output logic                     a_valid,
  output logic                     a_err,
  input  logic                     b_req,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0]    b_rdata,
  output logic                     b_valid,
  output logic                     busy
);

  localparam int OFF_W  = $clog2(BYTES);
  localparam int WIDX_W = ADDRESS_WIDTH - OFF_W;
  localparam int CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDX_W-1:0] DEPTH_IDX = WIDX_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0]   a_rdata_q, a_rdata_d;
  logic                    a_valid_q, a_valid_d;
  logic                    a_err_q, a_err_d;
  logic [DATA_WIDTH-1:0]   b_rdata_q, b_rdata_d;
  logic                    b_valid_q, b_valid_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    mem_we;
  logic [CNT_W-1:0]        mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  logic [OFF_W-1:0]        a_off;
  logic [WIDX_W-1:0]       a_widx, b_widx;
  logic [3:0]              a_nb;
  logic                    a_in_range, b_in_range, a_bad, a_store_ok, a_sign;
  logic [BYTES-1:0]        a_be;
  logic [DATA_WIDTH-1:0]   a_old, a_wshift, a_rshift, a_merged, a_load, b_word;
  logic                    unused_b_off;

  assign a_off        = a_addr[OFF_W-1:0];
  assign a_widx       = a_addr[ADDRESS_WIDTH-1:OFF_W];
  assign b_widx       = b_addr[ADDRESS_WIDTH-1:OFF_W];
  assign unused_b_off = ^b_addr[OFF_W-1:0];

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = clr_cnt_q;
    mem_wdata  = '0;
    a_be       = '0;
    a_merged   = '0;
    a_load     = '0;
    a_sign     = 1'b0;

    a_nb       = 4'd1 << a_size;
    a_in_range = a_widx < DEPTH_IDX;
    b_in_range = b_widx < DEPTH_IDX;
    a_bad      = (a_size == 2'd3) || ((int'(a_off) % int'(a_nb)) != 0) || !a_in_range;
    a_old      = a_in_range ? mem_q[a_widx[CNT_W-1:0]] : '0;
    b_word     = b_in_range ? mem_q[b_widx[CNT_W-1:0]] : '0;
    a_wshift   = a_wdata << (int'(a_off) * BYTE_WIDTH);
    a_rshift   = a_old >> (int'(a_off) * BYTE_WIDTH);

    for (int i = 0; i < BYTES; i++) begin
      a_be[i] = (i >= int'(a_off)) && (i < int'(a_off) + int'(a_nb));
      a_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = a_be[i] ? a_wshift[i*BYTE_WIDTH +: BYTE_WIDTH]
                                                     : a_old[i*BYTE_WIDTH +: BYTE_WIDTH];
    end

    case (a_size)
      2'd0:    a_sign = a_rshift[BYTE_WIDTH-1];
      2'd1:    a_sign = a_rshift[2*BYTE_WIDTH-1];
      default: a_sign = a_rshift[4*BYTE_WIDTH-1];
    endcase

    for (int i = 0; i < BYTES; i++) begin
      a_load[i*BYTE_WIDTH +: BYTE_WIDTH] = (i < int'(a_nb)) ? a_rshift[i*BYTE_WIDTH +: BYTE_WIDTH]
                                                            : {BYTE_WIDTH{a_sign & ~a_unsigned}};
    end

    a_store_ok = (state_q == ST_READY) && a_req && a_we && !a_bad;

`ifdef BLOCKRAM_LSU_BYPASS_EN
    // Write-first: port B sees the merged word of a same-cycle store.
    if (a_store_ok && (a_widx == b_widx)) b_word = a_merged;
`endif

    a_valid_d = 1'b0;
    a_err_d   = 1'b0;
    a_rdata_d = '0;
    b_valid_d = 1'b0;
    b_rdata_d = '0;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = ST_READY;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        mem_we    = a_store_ok;
        mem_waddr = a_widx[CNT_W-1:0];
        mem_wdata = a_merged;
        a_valid_d = a_req;
        a_err_d   = a_req && a_bad;
        a_rdata_d = (a_req && !a_we && !a_bad) ? a_load : '0;
        b_valid_d = b_req;
        b_rdata_d = b_req ? b_word : '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      a_rdata_q <= '0;
      a_valid_q <= 1'b0;
      a_err_q   <= 1'b0;
      b_rdata_q <= '0;
      b_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      a_rdata_q <= a_rdata_d;
      a_valid_q <= a_valid_d;
      a_err_q   <= a_err_d;
      b_rdata_q <= b_rdata_d;
      b_valid_q <= b_valid_d;
    end
  end

  // Array is not reset; the clear engine zeroes it, and no write lands on a reset edge.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign a_rdata = a_rdata_q;
  assign a_valid = a_valid_q;
  assign a_err   = a_err_q;
  assign b_rdata = b_rdata_q;
  assign b_valid = b_valid_q;
  assign busy    = (state_q == ST_CLEAR);

endmodule
